// File: rtl/pcie_egress_sequencer_if.sv
// ---------------------------------------------------------------------------
// pcie_egress_sequencer_if
// Per-TLP request bundle between the egress sequencer and the TLP builder.
//   o_egress_enable   : sequencer asks the builder to emit the current TLP
//   i_egress_finished : builder reports it is done with the current TLP
//   o_command         : TLP command byte (32-bit MWr / MRd)
//   o_flags           : TLP flags, passed through from the host side
//   o_address         : byte address of the current TLP
//   o_tag             : read tag of the current TLP (0 for writes)
//   o_tlp_dword_cnt   : TLP length in dwords (1024 encoded as 0)
// Signal names keep the sequencer's point of view: o_* are driven by the
// master (sequencer), i_* by the slave (builder).
// ---------------------------------------------------------------------------
interface pcie_egress_sequencer_if;
    logic        o_egress_enable;
    logic        i_egress_finished;
    logic [7:0]  o_command;
    logic [13:0] o_flags;
    logic [31:0] o_address;
    logic [7:0]  o_tag;
    logic [9:0]  o_tlp_dword_cnt;

    modport master (
        output o_egress_enable,
        output o_command,
        output o_flags,
        output o_address,
        output o_tag,
        output o_tlp_dword_cnt,
        input  i_egress_finished
    );

    modport slave (
        input  o_egress_enable,
        input  o_command,
        input  o_flags,
        input  o_address,
        input  o_tag,
        input  o_tlp_dword_cnt,
        output i_egress_finished
    );
endinterface

// File: rtl/pcie_egress_sequencer.sv
// ---------------------------------------------------------------------------
// pcie_egress_sequencer
// Splits one host transfer (memory write or read of N dwords) into legal
// TLPs: each bounded by max payload / max read request and never crossing a
// 4KB address boundary. Each TLP is handed to the builder with an
// enable/finished handshake. Read tags rotate 0..TAG_COUNT-1 and reads stall
// while every tag is in flight.
// Ports:
//   clk, rst            : core clock, asynchronous active-low reset
//   i_start             : 1-cycle start strobe, honoured only when idle
//   i_write             : 1 = memory write, 0 = memory read
//   i_address           : dword-aligned base byte address
//   i_dword_count       : total dwords of the transfer
//   i_flags             : TLP flags copied into each TLP
//   i_max_payload       : max write payload in dwords (0 means 32)
//   i_max_read_req      : max read request in dwords (0 means 32)
//   i_cpl_done          : 1-cycle strobe, one read tag fully completed
//   egress              : builder-side TLP request bundle (master side)
//   o_busy              : transfer in progress
//   o_done              : 1-cycle pulse when the transfer has fully finished
//   o_outstanding       : read tags currently in flight
// MAX_XFER_W must be at least 11.
// ---------------------------------------------------------------------------
module pcie_egress_sequencer #(
    parameter int TAG_COUNT  = 32,
    parameter int MAX_XFER_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_write,
    input  logic [31:0]             i_address,
    input  logic [MAX_XFER_W-1:0]   i_dword_count,
    input  logic [13:0]             i_flags,
    input  logic [9:0]              i_max_payload,
    input  logic [9:0]              i_max_read_req,
    input  logic                    i_cpl_done,
    pcie_egress_sequencer_if.master egress,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [8:0]              o_outstanding
);

    localparam logic [7:0] CMD_MWR_32B = 8'h40;
    localparam logic [7:0] CMD_MRD_32B = 8'h00;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CALC     = 3'd1;
    localparam logic [2:0] ST_STALL    = 3'd2;
    localparam logic [2:0] ST_ISSUE    = 3'd3;
    localparam logic [2:0] ST_WAIT_FIN = 3'd4;
    localparam logic [2:0] ST_WAIT_LOW = 3'd5;
    localparam logic [2:0] ST_DRAIN    = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    localparam logic [8:0] TAG_FULL = 9'(TAG_COUNT);
    localparam logic [7:0] TAG_LAST = 8'(TAG_COUNT - 1);

    // Smaller of two 11-bit dword lengths.
    function automatic logic [10:0] min_len(input logic [10:0] a, input logic [10:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [2:0]            state_r;
    logic                  write_r;
    logic [31:0]           addr_r;
    logic [MAX_XFER_W-1:0] remaining_r;
    logic [10:0]           len_r;
    logic [7:0]            tag_r;
    logic [8:0]            outstanding_r;

    logic                  enable_r;
    logic [7:0]            command_r;
    logic [13:0]           flags_r;
    logic [31:0]           address_r;
    logic [7:0]            tag_out_r;
    logic [9:0]            tlp_cnt_r;
    logic                  busy_r;
    logic                  done_r;

    logic [9:0]            lim_raw_s;
    logic [10:0]           lim_s;
    logic [10:0]           boundary_s;
    logic [10:0]           rem_clip_s;
    logic [10:0]           len_s;
    logic                  inc_s;
    logic                  dec_s;
    logic [8:0]            outstanding_nxt_s;

    // Length of the next TLP: remaining, size limit and distance to the 4KB edge.
    always_comb begin
        lim_raw_s = write_r ? i_max_payload : i_max_read_req;
        if (lim_raw_s == 10'd0) begin
            lim_s = 11'd32;
        end else begin
            lim_s = {1'b0, lim_raw_s};
        end
        // Dwords left before addr[11:0] wraps; 1..1024.
        boundary_s = 11'd1024 - {1'b0, addr_r[11:2]};
        if (remaining_r > MAX_XFER_W'(11'd1024)) begin
            rem_clip_s = 11'd1024;
        end else begin
            rem_clip_s = remaining_r[10:0];
        end
        len_s = min_len(min_len(rem_clip_s, lim_s), boundary_s);
    end

    // Tags in flight: a read issue and a release on the same edge cancel out,
    // and a release with nothing outstanding is dropped.
    always_comb begin
        inc_s = (state_r == ST_ISSUE) && !write_r;
        dec_s = i_cpl_done && (outstanding_r != 9'd0);
        if (inc_s && !dec_s) begin
            outstanding_nxt_s = outstanding_r + 9'd1;
        end else if (!inc_s && dec_s) begin
            outstanding_nxt_s = outstanding_r - 9'd1;
        end else begin
            outstanding_nxt_s = outstanding_r;
        end
    end

    // Transfer sequencing FSM with registered TLP fields and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            write_r       <= 1'b0;
            addr_r        <= 32'd0;
            remaining_r   <= '0;
            len_r         <= 11'd0;
            tag_r         <= 8'd0;
            outstanding_r <= 9'd0;
            enable_r      <= 1'b0;
            command_r     <= 8'd0;
            flags_r       <= 14'd0;
            address_r     <= 32'd0;
            tag_out_r     <= 8'd0;
            tlp_cnt_r     <= 10'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            outstanding_r <= outstanding_nxt_s;
            done_r        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        write_r     <= i_write;
                        addr_r      <= i_address;
                        remaining_r <= i_dword_count;
                        busy_r      <= 1'b1;
                        state_r     <= (i_dword_count == '0) ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    address_r <= addr_r;
                    len_r     <= len_s;
                    tlp_cnt_r <= len_s[9:0];
                    command_r <= write_r ? CMD_MWR_32B : CMD_MRD_32B;
                    tag_out_r <= write_r ? 8'd0 : tag_r;
                    flags_r   <= i_flags;
                    state_r   <= (!write_r && (outstanding_r == TAG_FULL)) ? ST_STALL : ST_ISSUE;
                end
                ST_STALL: begin
                    if (outstanding_r != TAG_FULL) begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    enable_r <= 1'b1;
                    if (!write_r) begin
                        tag_r <= (tag_r == TAG_LAST) ? 8'd0 : tag_r + 8'd1;
                    end
                    state_r <= ST_WAIT_FIN;
                end
                ST_WAIT_FIN: begin
                    if (egress.i_egress_finished) begin
                        enable_r    <= 1'b0;
                        addr_r      <= addr_r + {19'd0, len_r, 2'b00};
                        remaining_r <= remaining_r - MAX_XFER_W'(len_r);
                        state_r     <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    // Builder must drop finished before the next TLP is offered.
                    if (!egress.i_egress_finished) begin
                        if (remaining_r != '0) begin
                            state_r <= ST_CALC;
                        end else if (write_r) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (outstanding_r == 9'd0) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    enable_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign egress.o_egress_enable = enable_r;
    assign egress.o_command       = command_r;
    assign egress.o_flags         = flags_r;
    assign egress.o_address       = address_r;
    assign egress.o_tag           = tag_out_r;
    assign egress.o_tlp_dword_cnt = tlp_cnt_r;
    assign o_busy                 = busy_r;
    assign o_done                 = done_r;
    assign o_outstanding          = outstanding_r;

endmodule
